// File: rtl/vc_allocator_pkg.sv
// Shared sizing defaults and input-FSM encodings for the
// router's virtual-channel allocator.
package vc_allocator_pkg;

  localparam int N_IN  = 5;
  localparam int N_OUT = 5;
  localparam int N_VC  = 2;
  localparam int OUTW  = 3;
  localparam int VCW   = 1;

  typedef logic [1:0] ist_t;

  localparam ist_t ST_IDLE = 2'd0;
  localparam ist_t ST_WAIT = 2'd1;
  localparam ist_t ST_HOLD = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins,
// scanning upward and wrapping; next_ptr points past the winner.
module rr_arbiter
  import vc_allocator_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any_gnt,
  output logic [PW-1:0] next_ptr
);

  always_comb begin
    int idx;
    gnt      = '0;
    any_gnt  = 1'b0;
    next_ptr = ptr;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        any_gnt  = 1'b1;
        next_ptr = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/vc_allocator.sv
// Central VC allocator: per-output round-robin grant of the
// lowest free VC, with per-input owner tracking for release.
module vc_allocator
  import vc_allocator_pkg::*;
#(
  parameter int N_IN  = vc_allocator_pkg::N_IN,
  parameter int N_OUT = vc_allocator_pkg::N_OUT,
  parameter int N_VC  = vc_allocator_pkg::N_VC,
  parameter int OUTW  = vc_allocator_pkg::OUTW,
  parameter int VCW   = vc_allocator_pkg::VCW
) (
  input  logic                  clk,
  input  logic                  rs,
  input  logic [N_IN-1:0]       vc_req,
  input  logic [N_IN*OUTW-1:0]  req_out,
  input  logic [N_IN-1:0]       rel,
  output logic [N_IN-1:0]       vc_done,
  output logic [N_IN*VCW-1:0]   vc_id,
  output logic [N_OUT*N_VC-1:0] vc_busy,
  output logic                  err
);

  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NB = N_OUT * N_VC;

  ist_t              r_state [N_IN];
  logic [OUTW-1:0]   r_out   [N_IN];
  logic [VCW-1:0]    r_vc    [N_IN];
  logic [PW-1:0]     r_ptr   [N_OUT];
  logic [NB-1:0]     r_busy;
  logic [N_IN-1:0]   r_done;
  logic [N_IN*VCW-1:0] r_vcid;
  logic              r_err;

  logic [OUTW-1:0]   w_rout   [N_IN];
  logic [N_IN-1:0]   w_rvalid;
  logic [N_IN-1:0]   w_areq   [N_OUT];
  logic [N_IN-1:0]   w_gnt    [N_OUT];
  logic [N_OUT-1:0]  w_any;
  logic [PW-1:0]     w_nptr   [N_OUT];
  logic [N_OUT-1:0]  w_free;
  logic [VCW-1:0]    w_fvc    [N_OUT];
  logic [N_IN-1:0]   w_ign;
  logic [VCW-1:0]    w_gvc    [N_IN];
  logic [NB-1:0]     w_set;
  logic [NB-1:0]     w_clr;
  logic [N_IN-1:0]   w_errv;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_rout[i]   = req_out[i*OUTW +: OUTW];
      w_rvalid[i] = int'(w_rout[i]) < N_OUT;
    end
    // Lowest-index free VC per output, from the registered map only
    for (int o = 0; o < N_OUT; o++) begin
      w_free[o] = 1'b0;
      w_fvc[o]  = '0;
      for (int v = N_VC - 1; v >= 0; v--) begin
        if (!r_busy[o*N_VC + v]) begin
          w_free[o] = 1'b1;
          w_fvc[o]  = VCW'(v);
        end
      end
    end
    for (int o = 0; o < N_OUT; o++) begin
      w_areq[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_areq[o][i] = (r_state[i] == ST_WAIT) && vc_req[i] &&
                       w_rvalid[i] && (int'(w_rout[i]) == o) &&
                       w_free[o];
      end
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_arb
    rr_arbiter #(.N(N_IN), .PW(PW)) u_arb (
      .req      (w_areq[o]),
      .ptr      (r_ptr[o]),
      .gnt      (w_gnt[o]),
      .any_gnt  (w_any[o]),
      .next_ptr (w_nptr[o])
    );
  end

  always_comb begin
    w_ign  = '0;
    w_set  = '0;
    w_clr  = '0;
    w_errv = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_gvc[i] = '0;
      for (int o = 0; o < N_OUT; o++) begin
        if (w_gnt[o][i]) begin
          w_ign[i] = 1'b1;
          w_gvc[i] = w_fvc[o];
          w_set[o*N_VC + int'(w_fvc[o])] = 1'b1;
        end
      end
      if (rel[i] && r_state[i] == ST_HOLD)
        w_clr[int'(r_out[i])*N_VC + int'(r_vc[i])] = 1'b1;
      w_errv[i] = (rel[i] && r_state[i] != ST_HOLD) ||
                  (vc_req[i] && r_state[i] == ST_HOLD) ||
                  (vc_req[i] && r_state[i] == ST_WAIT &&
                   !w_rvalid[i]);
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_busy <= '0;
      r_done <= '0;
      r_vcid <= '0;
      r_err  <= 1'b0;
      for (int o = 0; o < N_OUT; o++) r_ptr[o] <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_state[i] <= ST_IDLE;
        r_out[i]   <= '0;
        r_vc[i]    <= '0;
      end
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_done <= w_ign;
      r_err  <= |w_errv;
      for (int o = 0; o < N_OUT; o++)
        if (w_any[o]) r_ptr[o] <= w_nptr[o];
      for (int i = 0; i < N_IN; i++) begin
        if (w_ign[i]) begin
          r_vcid[i*VCW +: VCW] <= w_gvc[i];
          r_out[i] <= w_rout[i];
          r_vc[i]  <= w_gvc[i];
        end
        case (r_state[i])
          ST_IDLE: if (vc_req[i]) r_state[i] <= ST_WAIT;
          ST_WAIT: begin
            if (w_ign[i])
              r_state[i] <= ST_HOLD;
            else if (!vc_req[i])
              r_state[i] <= ST_IDLE;
          end
          ST_HOLD: if (rel[i]) r_state[i] <= ST_IDLE;
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  assign vc_done = r_done;
  assign vc_id   = r_vcid;
  assign vc_busy = r_busy;
  assign err     = r_err;

endmodule
